biu_arbiter: RTL

//  Round-robin arbiter sharing the single BIU (and the 16-bit system bus behind it) between up to

---
 rtl/biu_arbiter.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/biu_arbiter.sv
// biu_arbiter: round-robin arbiter that shares the single BIU between up to four requesters.
// A granted owner keeps the BIU until it drops its request and the BIU reports ready.
// Every change of owner passes through RELEASE and IDLE, so no two requesters ever drive
// the BIU controls in the same cycle.
//
// Parameters:
//   NREQ         number of requesters, 2..4
//   TIMEOUT_CYC  HOLD-cycle limit before a forced release, 2..255 (ARB_TIMEOUT_EN builds only)
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   req             per-requester level request
//   sel_in          requester i sel code at [2i+1:2i]
//   op_sel_in       requester i op_sel code at [2i+1:2i]
//   ready_biu       BIU idle/complete
//   gnt             one-hot grant
//   owner           index of the current or last owner
//   cs_biu          BIU chip select, high while a grant is held
//   sel, op_sel     owner's codes while granted, otherwise 2'b00
//   busy            high in any state other than IDLE
//   timeout         one-cycle pulse on a forced release
//
// Optional feature macro: ARB_TIMEOUT_EN. It enables the HOLD timeout counter and the
// per-requester mask. When the macro is undefined, timeout is tied to 0.
module biu_arbiter #(
  parameter int unsigned NREQ        = 2,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] sel_in,
  input  logic [2*NREQ-1:0] op_sel_in,
  input  logic              ready_biu,
  output logic [NREQ-1:0]   gnt,
  output logic [1:0]        owner,
  output logic              cs_biu,
  output logic [1:0]        sel,
  output logic [1:0]        op_sel,
  output logic              busy,
  output logic              timeout
);

  localparam logic [2:0] NREQ3    = 3'(NREQ);
  localparam logic [1:0] LAST_IDX = 2'(NREQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      owner_q, owner_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            cs_q, cs_d;
  logic            busy_q, busy_d;

  // Zero-extended copies give every NREQ a fixed 2-bit index space.
  logic [3:0]      req4;
  logic [7:0]      sel_in8, op_sel_in8;
  logic            req_own;
  logic [3:0]      own_oh;
  logic [NREQ-1:0] elig;

  assign req4       = 4'(req);
  assign sel_in8    = 8'(sel_in);
  assign op_sel_in8 = 8'(op_sel_in);
  assign req_own    = req4[owner_q];
  assign own_oh     = 4'b0001 << owner_q;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TLIM = 8'(TIMEOUT_CYC - 1);

  logic [7:0]      cnt_q, cnt_d;
  logic [NREQ-1:0] mask_q, mask_d;
  logic            tmo_q, tmo_d;

  assign elig    = req & ~mask_q;
  assign timeout = tmo_q;
`else
  assign elig    = req;
  assign timeout = 1'b0;
`endif

  // Round-robin pick: first eligible requester at or after ptr, wrapping modulo NREQ.
  logic       win_vld;
  logic [1:0] win_idx;

  always_comb begin
    logic [2:0] idx;
    logic [3:0] elig4;
    win_vld = 1'b0;
    win_idx = ptr_q;
    elig4   = 4'(elig);
    for (int k = 0; k < 4; k++) begin
      idx = 3'(ptr_q) + 3'(k);
      if (idx >= NREQ3) idx = idx - NREQ3;
      if (3'(k) < NREQ3 && !win_vld && elig4[idx[1:0]]) begin
        win_vld = 1'b1;
        win_idx = idx[1:0];
      end
    end
  end

  // Next state plus the values that the output registers take on the next edge.
  always_comb begin
    logic [3:0] next_oh;
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    mask_d  = mask_q & req;   // a mask bit clears once its request is seen low
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          owner_d = win_idx;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        state_d = ST_HOLD;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = 8'd0;
`endif
      end
      ST_HOLD: begin
        if (!req_own && ready_biu) begin
          state_d = ST_RELEASE;
`ifdef ARB_TIMEOUT_EN
        end else if (req_own && cnt_q == TLIM) begin
          state_d = ST_RELEASE;
          tmo_d   = 1'b1;
          mask_d  = mask_d | own_oh[NREQ-1:0];
        end else begin
          cnt_d   = cnt_q + 8'd1;
`endif
        end
      end
      ST_RELEASE: begin
        ptr_d   = (owner_q == LAST_IDX) ? 2'd0 : owner_q + 2'd1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    next_oh = 4'b0001 << owner_d;
    cs_d    = (state_d == ST_GRANT) || (state_d == ST_HOLD);
    gnt_d   = cs_d ? next_oh[NREQ-1:0] : '0;
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= 2'd0;
      ptr_q   <= 2'd0;
      gnt_q   <= '0;
      cs_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= 8'd0;
      mask_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mask_q <= mask_d;
      tmo_q  <= tmo_d;
    end
  end
`endif

  // The code mux follows the registered owner so that sel and op_sel track the inputs in HOLD.
  logic [1:0] sel_own, op_sel_own;

  always_comb begin
    unique case (owner_q)
      2'd0:    begin sel_own = sel_in8[1:0]; op_sel_own = op_sel_in8[1:0]; end
      2'd1:    begin sel_own = sel_in8[3:2]; op_sel_own = op_sel_in8[3:2]; end
      2'd2:    begin sel_own = sel_in8[5:4]; op_sel_own = op_sel_in8[5:4]; end
      default: begin sel_own = sel_in8[7:6]; op_sel_own = op_sel_in8[7:6]; end
    endcase
  end

  assign gnt    = gnt_q;
  assign owner  = owner_q;
  assign cs_biu = cs_q;
  assign busy   = busy_q;
  assign sel    = cs_q ? sel_own    : 2'b00;
  assign op_sel = cs_q ? op_sel_own : 2'b00;

endmodule
